// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon round controller and its LFSR.
package simon_pkg;

   localparam int                     SIMON_WIDTH     = 8;
   localparam logic [SIMON_WIDTH-1:0] SIMON_LFSR_SEED = 8'h5A;
   localparam logic [SIMON_WIDTH-1:0] SIMON_LFSR_TAPS = 8'hB8;
   localparam logic [7:0]             ROUND_SAT       = 8'd255;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHOW,
      ST_ARMED,
      ST_WAIT_DONE
   } state_t;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == ROUND_SAT) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/simon_lfsr.sv
// Free-running Galois right-shift LFSR; an all-zero value is steered back to SEED.
module simon_lfsr
   import simon_pkg::*;
#(
   parameter int               WIDTH = SIMON_WIDTH,
   parameter logic [WIDTH-1:0] TAPS  = SIMON_LFSR_TAPS,
   parameter logic [WIDTH-1:0] SEED  = SIMON_LFSR_SEED
)(
   input  logic             clock,
   input  logic             reset,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   always_comb begin
      q_d = (q_q >> 1) ^ (q_q[0] ? TAPS : '0);
      // Zero is a lock-up state for this structure, so recover to the seed.
      if (q_q == '0) q_d = SEED;
   end

   always_ff @(posedge clock) begin
      if (reset) q_q <= SEED;
      else       q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/simon_round_ctrl.sv
// Simon round generator: captures an LFSR value on start, shows it, strobes load, counts rounds.
// Optional start-button debounce is enabled by defining SIMON_ROUND_CTRL_DEBOUNCE_EN.
module simon_round_ctrl
   import simon_pkg::*;
#(
   parameter int               WIDTH       = SIMON_WIDTH,
   parameter int               SHOW_CYCLES = 100000000,
   parameter logic [WIDTH-1:0] LFSR_TAPS   = SIMON_LFSR_TAPS,
   parameter logic [WIDTH-1:0] LFSR_SEED   = SIMON_LFSR_SEED
`ifdef SIMON_ROUND_CTRL_DEBOUNCE_EN
   ,
   parameter int               DEBOUNCE_CYCLES = 1000000
`endif
)(
   input  logic             clock,
   input  logic             reset,
   input  logic             start_game,
   input  logic             fsm_busy,
   output logic [WIDTH-1:0] random_num,
   output logic             load,
   output logic [WIDTH-1:0] pattern_led,
   output logic             showing,
   output logic [7:0]       round_count
);

   localparam logic [31:0] SHOW_M1 = 32'(SHOW_CYCLES - 1);

   logic [WIDTH-1:0] lfsr_val;
   logic             sync1_q, sync2_q, prev_q;
   logic             level;
   logic             rise;
   state_t           state_q, state_d;
   logic [31:0]      timer_q, timer_d;
   logic [WIDTH-1:0] rn_q, rn_d;
   logic             load_q, load_d;
   logic [7:0]       rc_q, rc_d;

   simon_lfsr #(
      .WIDTH (WIDTH),
      .TAPS  (LFSR_TAPS),
      .SEED  (LFSR_SEED)
   ) u_lfsr (
      .clock (clock),
      .reset (reset),
      .q     (lfsr_val)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
      end else begin
         sync1_q <= start_game;
         sync2_q <= sync1_q;
         prev_q  <= level;
      end
   end

`ifdef SIMON_ROUND_CTRL_DEBOUNCE_EN
   logic        deb_q;
   logic [31:0] deb_cnt_q;

   // Level only follows the synchronized input after it differs for DEBOUNCE_CYCLES in a row.
   always_ff @(posedge clock) begin
      if (reset) begin
         deb_q     <= 1'b0;
         deb_cnt_q <= '0;
      end else if (sync2_q == deb_q) begin
         deb_cnt_q <= '0;
      end else if (deb_cnt_q == 32'(DEBOUNCE_CYCLES - 1)) begin
         deb_q     <= sync2_q;
         deb_cnt_q <= '0;
      end else begin
         deb_cnt_q <= deb_cnt_q + 32'd1;
      end
   end

   assign level = deb_q;
`else
   assign level = sync2_q;
`endif

   assign rise = level & ~prev_q;

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      rn_d    = rn_q;
      load_d  = 1'b0;
      rc_d    = rc_q;
      case (state_q)
         ST_IDLE: begin
            if (rise) begin
               rn_d    = lfsr_val;
               timer_d = SHOW_M1;
               state_d = ST_SHOW;
            end
         end
         ST_SHOW: begin
            // load is registered, so it is raised one cycle early to coincide with timer==0.
            if (timer_q == 32'd1) load_d = 1'b1;
            if (timer_q == '0) state_d = ST_ARMED;
            else               timer_d = timer_q - 32'd1;
         end
         ST_ARMED: begin
            if (fsm_busy) state_d = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (!fsm_busy) begin
               rc_d    = sat_inc(rc_q);
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
         rn_q    <= '0;
         load_q  <= 1'b0;
         rc_q    <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         rn_q    <= rn_d;
         load_q  <= load_d;
         rc_q    <= rc_d;
      end
   end

   assign random_num  = rn_q;
   assign load        = load_q;
   assign showing     = (state_q == ST_SHOW);
   assign pattern_led = showing ? rn_q : '0;
   assign round_count = rc_q;

endmodule

// File: tb/tb_simon_round_ctrl.sv
// Directed bench for simon_round_ctrl: per-cycle vector table plus reset-mid-round and saturation sequences.
module tb_simon_round_ctrl;

   localparam int W = 8;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         start_game = 1'b0;
   logic         fsm_busy = 1'b0;
   logic [W-1:0] random_num;
   logic         load;
   logic [W-1:0] pattern_led;
   logic         showing;
   logic [7:0]   round_count;

   int           errors = 0;
   int           checks = 0;
   logic [W-1:0] model_lfsr = 8'h5A;
   logic [W-1:0] exp_q[$];
   logic [7:0]   exp_rc;

   typedef struct {
      logic         start;
      logic         busy;
      logic [W-1:0] lfsr;
      logic         show;
      logic [W-1:0] led;
      logic         ld;
      logic [W-1:0] rn;
      logic [7:0]   rc;
   } vec_t;

   vec_t tbl[16];

   simon_round_ctrl #(
      .SHOW_CYCLES (4)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .start_game  (start_game),
      .fsm_busy    (fsm_busy),
      .random_num  (random_num),
      .load        (load),
      .pattern_led (pattern_led),
      .showing     (showing),
      .round_count (round_count)
   );

   always #5 clock = ~clock;

   function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] v);
      logic [W-1:0] n;
      n = (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
      if (v == 8'h00) n = 8'h5A;
      return n;
   endfunction

   task automatic tick();
      @(posedge clock);
      if (reset) model_lfsr = 8'h5A;
      else       model_lfsr = lfsr_step(model_lfsr);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_round();
      int n;
      start_game = 1'b1;
      tick();
      start_game = 1'b0;
      tick();
      chk("lfsr_model", 32'(dut.lfsr_val), 32'(model_lfsr));
      exp_q.push_back(model_lfsr);
      n = 0;
      while (!load && n < 20) begin
         tick();
         n++;
      end
      if (!load) begin
         chk("load_timeout", 32'(load), 32'd1);
         void'(exp_q.pop_front());
      end else begin
         chk("round_rn", 32'(random_num), 32'(exp_q.pop_front()));
      end
      // Busy is already high when ARMED is entered.
      fsm_busy = 1'b1;
      tick();
      tick();
      fsm_busy = 1'b0;
      tick();
      exp_rc = (exp_rc == 8'd255) ? 8'd255 : exp_rc + 8'd1;
      chk("round_count", 32'(round_count), 32'(exp_rc));
   endtask

   initial begin
      int n;
      logic seen_load;

      //        start busy  lfsr   show led    ld    rn     rc
      tbl[0]  = '{1'b1, 1'b0, 8'h5A, 1'b0, 8'h00, 1'b0, 8'h00, 8'd0};
      tbl[1]  = '{1'b1, 1'b0, 8'h2D, 1'b0, 8'h00, 1'b0, 8'h00, 8'd0};
      tbl[2]  = '{1'b1, 1'b0, 8'hAE, 1'b0, 8'h00, 1'b0, 8'h00, 8'd0};
      tbl[3]  = '{1'b0, 1'b0, 8'h57, 1'b1, 8'hAE, 1'b0, 8'hAE, 8'd0};
      tbl[4]  = '{1'b1, 1'b0, 8'h93, 1'b1, 8'hAE, 1'b0, 8'hAE, 8'd0};
      tbl[5]  = '{1'b1, 1'b0, 8'hF1, 1'b1, 8'hAE, 1'b0, 8'hAE, 8'd0};
      tbl[6]  = '{1'b0, 1'b0, 8'hC0, 1'b1, 8'hAE, 1'b1, 8'hAE, 8'd0};
      tbl[7]  = '{1'b0, 1'b1, 8'h60, 1'b0, 8'h00, 1'b0, 8'hAE, 8'd0};
      tbl[8]  = '{1'b0, 1'b1, 8'h30, 1'b0, 8'h00, 1'b0, 8'hAE, 8'd0};
      tbl[9]  = '{1'b1, 1'b1, 8'h18, 1'b0, 8'h00, 1'b0, 8'hAE, 8'd0};
      tbl[10] = '{1'b0, 1'b1, 8'h0C, 1'b0, 8'h00, 1'b0, 8'hAE, 8'd0};
      tbl[11] = '{1'b0, 1'b1, 8'h06, 1'b0, 8'h00, 1'b0, 8'hAE, 8'd0};
      tbl[12] = '{1'b0, 1'b0, 8'h03, 1'b0, 8'h00, 1'b0, 8'hAE, 8'd0};
      tbl[13] = '{1'b0, 1'b0, 8'hB9, 1'b0, 8'h00, 1'b0, 8'hAE, 8'd1};
      tbl[14] = '{1'b0, 1'b0, 8'hE4, 1'b0, 8'h00, 1'b0, 8'hAE, 8'd1};
      tbl[15] = '{1'b0, 1'b0, 8'h72, 1'b0, 8'h00, 1'b0, 8'hAE, 8'd1};

      reset = 1'b1;
      repeat (3) tick();
      chk("rst_rn", 32'(random_num), 32'd0);
      chk("rst_load", 32'(load), 32'd0);
      chk("rst_led", 32'(pattern_led), 32'd0);
      chk("rst_show", 32'(showing), 32'd0);
      chk("rst_rc", 32'(round_count), 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 16; i++) begin
         chk($sformatf("v%0d_lfsr", i), 32'(dut.lfsr_val), 32'(tbl[i].lfsr));
         chk($sformatf("v%0d_show", i), 32'(showing), 32'(tbl[i].show));
         chk($sformatf("v%0d_led", i), 32'(pattern_led), 32'(tbl[i].led));
         chk($sformatf("v%0d_load", i), 32'(load), 32'(tbl[i].ld));
         chk($sformatf("v%0d_rn", i), 32'(random_num), 32'(tbl[i].rn));
         chk($sformatf("v%0d_rc", i), 32'(round_count), 32'(tbl[i].rc));
         start_game = tbl[i].start;
         fsm_busy   = tbl[i].busy;
         tick();
      end
      start_game = 1'b0;
      fsm_busy   = 1'b0;

      // Reset in the second SHOW cycle (timer==2).
      start_game = 1'b1;
      tick();
      start_game = 1'b0;
      n = 0;
      while (!showing && n < 10) begin
         tick();
         n++;
      end
      chk("mid_show_reached", 32'(showing), 32'd1);
      tick();
      chk("mid_show_still", 32'(showing), 32'd1);
      chk("mid_show_noload", 32'(load), 32'd0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("mid_rst_load", 32'(load), 32'd0);
      chk("mid_rst_led", 32'(pattern_led), 32'd0);
      chk("mid_rst_rn", 32'(random_num), 32'd0);
      chk("mid_rst_show", 32'(showing), 32'd0);
      chk("mid_rst_lfsr", 32'(dut.lfsr_val), 32'h5A);
      chk("mid_rst_rc", 32'(round_count), 32'd0);
      seen_load = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (load) seen_load = 1'b1;
      end
      chk("mid_rst_no_load", 32'(seen_load), 32'd0);

      exp_rc = 8'd0;
      for (int r = 0; r < 257; r++) do_round();
      chk("sat_final", 32'(round_count), 32'd255);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
